// File: rtl/markov16_decoder_if.sv
// Residual-in / decoded-bit-out stream bundle for markov16_decoder.
// master = stream neighbours (upstream source and downstream sink), slave = decoder.
interface markov16_decoder_if #(
  parameter int HIST_W = 4
) ();
  logic              in_valid;
  logic              in_ready;
  logic              res_in;
  logic              out_valid;
  logic              out_ready;
  logic              bit_out;
  logic [HIST_W-1:0] lane;

  modport master (
    output in_valid, res_in, out_ready,
    input  in_ready, out_valid, bit_out, lane
  );

  modport slave (
    input  in_valid, res_in, out_ready,
    output in_ready, out_valid, bit_out, lane
  );
endinterface

// File: rtl/markov16_decoder.sv
// Context-model bit decoder: rebuilds original bits from residuals using per-history saturating counters.
// Define MARKOV_DEC_STATS_EN to add the mispredict_cnt / bit_cnt statistics outputs.
module markov16_decoder #(
  parameter int HIST_W   = 4,
  parameter int CTR_W    = 2,
  parameter int CTR_INIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  markov16_decoder_if.slave s
`ifdef MARKOV_DEC_STATS_EN
  ,
  output logic [15:0]       mispredict_cnt,
  output logic [15:0]       bit_cnt
`endif
);

  localparam int NCTX = 1 << HIST_W;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(CTR_INIT);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  logic [HIST_W-1:0] hist;
  logic [CTR_W-1:0]  ctr [NCTX];
  logic [CTR_W-1:0]  ctr_cur;
  logic [CTR_W-1:0]  ctr_nxt;
  logic              accept;
  logic              pred;
  logic              d;

  assign s.in_ready = (!s.out_valid || s.out_ready) && !clear;
  assign accept     = s.in_valid && s.in_ready;

  // Prediction always comes from the pre-update history; one bit per cycle means no bypass is needed.
  assign ctr_cur = ctr[hist];
  assign pred    = ctr_cur[CTR_W-1];
  assign d       = s.res_in ^ pred;

  always_comb begin
    ctr_nxt = ctr_cur;
    if (d) begin
      if (ctr_cur != CTR_MAX) ctr_nxt = ctr_cur + 1'b1;
    end else begin
      if (ctr_cur != '0) ctr_nxt = ctr_cur - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist        <= '0;
      for (int i = 0; i < NCTX; i++) ctr[i] <= CTR_RST;
      s.out_valid <= 1'b0;
      s.bit_out   <= 1'b0;
      s.lane      <= '0;
    end else if (clear) begin
      hist        <= '0;
      for (int i = 0; i < NCTX; i++) ctr[i] <= CTR_RST;
      s.out_valid <= 1'b0;
      s.bit_out   <= 1'b0;
      s.lane      <= '0;
    end else begin
      if (accept) begin
        ctr[hist]   <= ctr_nxt;
        hist        <= {hist[HIST_W-2:0], d};
        s.out_valid <= 1'b1;
        s.bit_out   <= d;
        s.lane      <= hist;
      end else if (s.out_ready) begin
        s.out_valid <= 1'b0;
      end
    end
  end

`ifdef MARKOV_DEC_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredict_cnt <= '0;
      bit_cnt        <= '0;
    end else if (clear) begin
      mispredict_cnt <= '0;
      bit_cnt        <= '0;
    end else if (accept) begin
      bit_cnt <= bit_cnt + 16'd1;
      if (s.res_in && (mispredict_cnt != 16'hFFFF)) mispredict_cnt <= mispredict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_markov16_decoder.sv
// Directed and round-trip bench for markov16_decoder; honours MARKOV_DEC_STATS_EN when defined.
module tb_markov16_decoder;

  localparam int NRT = 1000;
  localparam int NV  = 16;

  logic clk;
  logic reset;
  logic clear;

  markov16_decoder_if #(.HIST_W(4)) bus ();

`ifdef MARKOV_DEC_STATS_EN
  logic [15:0] mispredict_cnt;
  logic [15:0] bit_cnt;
`endif

  markov16_decoder #(.HIST_W(4), .CTR_W(2), .CTR_INIT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .s     (bus.slave)
`ifdef MARKOV_DEC_STATS_EN
    ,
    .mispredict_cnt (mispredict_cnt),
    .bit_cnt        (bit_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic       res;
    logic       exp_bit;
    logic [3:0] exp_lane;
  } vec_t;

  vec_t vecs [NV];

  // Encoder reference model: the spec's predictor running on source bits.
  logic [3:0] m_hist;
  logic [1:0] m_ctr [16];

  logic       src_q  [NRT];
  logic       res_q  [NRT];
  logic [3:0] lane_q [NRT];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_hist = 4'd0;
    for (int k = 0; k < 16; k++) m_ctr[k] = 2'd1;
  endtask

  task automatic m_enc(input logic b, output logic r, output logic [3:0] ln);
    logic p;
    p  = m_ctr[m_hist][1];
    r  = b ^ p;
    ln = m_hist;
    if (b && m_ctr[m_hist] != 2'd3) m_ctr[m_hist] = m_ctr[m_hist] + 2'd1;
    else if (!b && m_ctr[m_hist] != 2'd0) m_ctr[m_hist] = m_ctr[m_hist] - 2'd1;
    m_hist = {m_hist[2:0], b};
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic push(input logic r);
    bus.in_valid  = 1'b1;
    bus.res_in    = r;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int rcv;
    int cyc;
    int mis_exp;
    logic [7:0] bp_src;

    // basic decode, then one more bit on context 13
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 4'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 4'd1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'd3};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 4'd6};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'd13};
    // training onto lane 15, saturation at 11, then a mispredict and a fresh lane
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 4'd0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 4'd1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 4'd3};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 4'd7};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 4'd15};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 4'd15};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 4'd15};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 4'd15};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 4'd14};

    reset = 1'b1;
    clear = 1'b0;
    bus.in_valid  = 1'b0;
    bus.res_in    = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_bit_out",   bus.bit_out, 0);
    chk("rst_lane",      bus.lane, 0);
    chk("rst_in_ready",  bus.in_ready, 1);
`ifdef MARKOV_DEC_STATS_EN
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_mis_cnt", mispredict_cnt, 0);
`endif
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst) do_reset();
      push(vecs[i].res);
      chk($sformatf("vec%0d_valid", i), bus.out_valid, 1);
      chk($sformatf("vec%0d_bit", i),   bus.bit_out, vecs[i].exp_bit);
      chk($sformatf("vec%0d_lane", i),  bus.lane, vecs[i].exp_lane);
    end
    bus.in_valid = 1'b0;

    // backpressure: stalled output must hold and block input
    bp_src = 8'b1011_0010;
    m_reset();
    for (int k = 0; k < 8; k++) begin
      src_q[k] = bp_src[7-k];
      m_enc(src_q[k], res_q[k], lane_q[k]);
    end
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.res_in    = res_q[0];
    @(posedge clk);
    @(negedge clk);
    chk("bp_first_valid", bus.out_valid, 1);
    chk("bp_first_bit",   bus.bit_out, src_q[0]);
    bus.res_in = res_q[1];
    repeat (3) begin
      #1;
      chk("bp_in_ready_low", bus.in_ready, 0);
      chk("bp_hold_valid",   bus.out_valid, 1);
      chk("bp_hold_bit",     bus.bit_out, src_q[0]);
      chk("bp_hold_lane",    bus.lane, lane_q[0]);
      @(posedge clk);
      @(negedge clk);
    end
    for (int k = 1; k < 8; k++) begin
      push(res_q[k]);
      chk($sformatf("bp_resume_bit%0d", k),  bus.bit_out, src_q[k]);
      chk($sformatf("bp_resume_lane%0d", k), bus.lane, lane_q[k]);
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("bp_drain_valid", bus.out_valid, 0);

    // clear colliding with in_valid mid-stream
    do_reset();
    push(1'b1);
    push(1'b1);
    clear = 1'b1;
    bus.res_in = 1'b0;
    #1;
    chk("clr_in_ready", bus.in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    chk("clr_out_valid", bus.out_valid, 0);
`ifdef MARKOV_DEC_STATS_EN
    chk("clr_bit_cnt", bit_cnt, 0);
`endif
    clear = 1'b0;
    push(1'b0);
    chk("clr_next_valid", bus.out_valid, 1);
    chk("clr_next_bit",   bus.bit_out, 0);
    chk("clr_next_lane",  bus.lane, 0);
    push(1'b1);
    chk("clr_next2_bit",  bus.bit_out, 1);
    chk("clr_next2_lane", bus.lane, 0);
    bus.in_valid = 1'b0;

    // asynchronous reset between edges while holding a valid output
    do_reset();
    push(1'b1);
    push(1'b1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("arst_pre_valid", bus.out_valid, 1);
    chk("arst_pre_lane",  bus.lane, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_bit_out",   bus.bit_out, 0);
    chk("arst_lane",      bus.lane, 0);
    #1;
    reset = 1'b0;
    @(negedge clk);
    push(1'b1);
    chk("arst_post_bit0",  bus.bit_out, 1);
    chk("arst_post_lane0", bus.lane, 0);
    push(1'b1);
    chk("arst_post_bit1",  bus.bit_out, 1);
    chk("arst_post_lane1", bus.lane, 1);
    bus.in_valid = 1'b0;

    // round trip through the encoder model with random downstream stalls
    m_reset();
    mis_exp = 0;
    for (int i = 0; i < NRT; i++) begin
      src_q[i] = ((i % 5) < 3) ^ ($urandom_range(0, 7) == 0);
      m_enc(src_q[i], res_q[i], lane_q[i]);
      if (res_q[i]) mis_exp++;
    end
    do_reset();
    sent = 0;
    rcv  = 0;
    cyc  = 0;
    while ((rcv < NRT) && (cyc < 6000)) begin
      if (sent < NRT) begin
        bus.in_valid = 1'b1;
        bus.res_in   = res_q[sent];
      end else begin
        bus.in_valid = 1'b0;
        bus.res_in   = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        chk("rt_bit",  bus.bit_out, src_q[rcv]);
        chk("rt_lane", bus.lane, lane_q[rcv]);
        rcv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    chk("rt_received_all", rcv, NRT);
    bus.in_valid = 1'b0;
`ifdef MARKOV_DEC_STATS_EN
    chk("rt_bit_cnt", bit_cnt, NRT);
    chk("rt_mis_cnt", mispredict_cnt, mis_exp);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
